// File: rtl/tv80_bus_pkg.sv
// Shared types for the tv80s bus responder: FSM states, bus-cycle classes,
// the di reset value and the strobe decoder.
package tv80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } bus_state_e;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_MRD  = 3'd1,
        C_MWR  = 3'd2,
        C_IORD = 3'd3,
        C_IOWR = 3'd4,
        C_INTA = 3'd5
    } cyc_class_e;

    localparam logic [7:0] DI_RESET = 8'hFF;

    // Classify the current strobe pattern; refresh (mreq with rfsh) maps to none.
    function automatic cyc_class_e decode_class(
        input logic m1_n,
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic rfsh_n
    );
        cyc_class_e cls;
        if (!mreq_n && !rd_n && rfsh_n)       cls = C_MRD;
        else if (!mreq_n && !wr_n)            cls = C_MWR;
        else if (!iorq_n && !rd_n && m1_n)    cls = C_IORD;
        else if (!iorq_n && !wr_n)            cls = C_IOWR;
        else if (!iorq_n && !m1_n)            cls = C_INTA;
        else                                  cls = C_NONE;
        return cls;
    endfunction

endpackage

// File: rtl/tv80_bus_responder_wait_gen.sv
// Wait-state generator: counts the stretch of the current bus cycle and
// drives the combinational wait_n request seen by the CPU.
module tv80_wait_gen
    import tv80_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       class_active,
    input  logic [3:0] load_val,
    input  bus_state_e state,
    output logic       wait_n,
    output logic       done
);

    logic [3:0] cnt_r;

    // Wait counter: loaded when a cycle is decoded, counts down while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (!class_active) begin
            cnt_r <= 4'd0;
        end else if (state == IDLE) begin
            cnt_r <= load_val;
        end else if ((state == WAITING) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 4'd1);

    // wait_n low from the decode cycle through the last waiting cycle; forced high in reset
    always_comb begin
        wait_n = 1'b1;
        if (rst_n && class_active &&
            (((state == IDLE) && (load_val != 4'd0)) || (state == WAITING))) begin
            wait_n = 1'b0;
        end else begin
            wait_n = 1'b1;
        end
    end

endmodule

// File: rtl/tv80_bus_responder.sv
// Memory/IO target for the tv80s bus: mirrored byte RAM, small IO bank,
// programmable wait states, interrupt-acknowledge vector and a preload port.
// Optional write protection below WP_TOP is compiled in with TV80_BUS_WP_EN.
module tv80_bus_responder
    import tv80_bus_pkg::*;
#(
    parameter int          MEM_AW   = 12,
    parameter int          IO_AW    = 4,
    parameter int          WAIT_MEM = 0,
    parameter int          WAIT_IO  = 1,
    parameter logic [7:0]  INTA_VEC = 8'hFF,
    parameter logic [15:0] WP_TOP   = 16'h0000
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       A,
    input  logic [7:0]        cpu_do,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    output logic [7:0]        di,
    output logic              wait_n,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              wp_hit
);

    localparam int         MEM_DEPTH  = 1 << MEM_AW;
    localparam int         IO_DEPTH   = 1 << IO_AW;
    localparam logic [3:0] WAIT_MEM_L = 4'(WAIT_MEM);
    localparam logic [3:0] WAIT_IO_L  = 4'(WAIT_IO);

    logic [7:0] ram_r [MEM_DEPTH];
    logic [7:0] io_r  [IO_DEPTH];

    cyc_class_e        class_s;
    cyc_class_e        class_r;
    bus_state_e        state_r;
    bus_state_e        state_s;
    logic              class_active_s;
    logic [3:0]        load_s;
    logic              done_s;
    logic              commit_s;
    logic              mem_we_s;
    logic              io_we_s;
    logic              wp_block_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [IO_AW-1:0]  io_addr_s;

    assign mem_addr_s = A[MEM_AW-1:0];
    assign io_addr_s  = A[IO_AW-1:0];

    // Decode the bus cycle class and its wait-state load value
    always_comb begin
        class_s        = decode_class(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
        class_active_s = (class_s != C_NONE);
        case (class_s)
            C_MRD, C_MWR:   load_s = WAIT_MEM_L;
            C_IORD, C_IOWR: load_s = WAIT_IO_L;
            default:        load_s = 4'd0;
        endcase
    end

    tv80_wait_gen u_wait_gen (
        .clk          (clk),
        .rst_n        (reset_n),
        .class_active (class_active_s),
        .load_val     (load_s),
        .state        (state_r),
        .wait_n       (wait_n),
        .done         (done_s)
    );

    // Next-state logic; any strobe release before the access drops the cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (class_active_s) begin
                    state_s = (load_s != 4'd0) ? WAITING : ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            WAITING: begin
                if (!class_active_s)  state_s = IDLE;
                else if (done_s)      state_s = ACTIVE;
                else                  state_s = WAITING;
            end
            ACTIVE: begin
                if (!class_active_s)  state_s = IDLE;
                else                  state_s = DONE;
            end
            DONE: begin
                if (mreq_n && iorq_n) state_s = IDLE;
                else                  state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state and latched cycle class
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            class_r <= C_NONE;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && class_active_s) begin
                class_r <= class_s;
            end else begin
                class_r <= class_r;
            end
        end
    end

    // The single write of a bus cycle happens on the ACTIVE edge
    always_comb begin
        commit_s = (state_r == ACTIVE) && class_active_s;
        mem_we_s = commit_s && (class_r == C_MWR) && !wp_block_s;
        io_we_s  = commit_s && (class_r == C_IOWR);
    end

`ifdef TV80_BUS_WP_EN
    logic wp_hit_r;

    // Writes below WP_TOP are blocked
    always_comb begin
        wp_block_s = (A < WP_TOP);
    end

    // One-clock pulse for each blocked memory write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_hit_r <= 1'b0;
        end else begin
            wp_hit_r <= commit_s && (class_r == C_MWR) && wp_block_s;
        end
    end

    assign wp_hit = wp_hit_r;
`else
    logic unused_s;

    assign wp_block_s = 1'b0;
    assign wp_hit     = 1'b0;
    assign unused_s   = ^{A[15:MEM_AW], WP_TOP};
`endif

    // RAM writes: the preload port is applied last so it wins on a same-address collision
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            ram_r[mem_addr_s] <= cpu_do;
        end
        if (ld_we) begin
            ram_r[ld_addr] <= ld_data;
        end
    end

    // IO register bank writes
    always_ff @(posedge clk) begin
        if (io_we_s) begin
            io_r[io_addr_s] <= cpu_do;
        end
    end

    // Registered read data; holds when no read-type cycle is on the bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di <= DI_RESET;
        end else begin
            case (class_s)
                C_MRD:   di <= ram_r[mem_addr_s];
                C_IORD:  di <= io_r[io_addr_s];
                C_INTA:  di <= INTA_VEC;
                default: di <= di;
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_bus_responder.sv
// Randomized self-checking bench for tv80_bus_responder with a bus-cycle
// level reference model (cycle age, per-cycle commit, byte arrays).
module tb_tv80_bus_responder;

    localparam int          MEM_AW   = 12;
    localparam int          IO_AW    = 4;
    localparam int          WAIT_MEM = 2;
    localparam int          WAIT_IO  = 1;
    localparam logic [7:0]  INTA_VEC = 8'hE7;
    localparam logic [15:0] WP_TOP   = 16'h1000;
`ifdef TV80_BUS_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [15:0]       A;
    logic [7:0]        cpu_do;
    logic              m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [7:0]        di;
    logic              wait_n;
    logic              ld_we;
    logic [MEM_AW-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              wp_hit;

    tv80_bus_responder #(
        .MEM_AW(MEM_AW), .IO_AW(IO_AW), .WAIT_MEM(WAIT_MEM), .WAIT_IO(WAIT_IO),
        .INTA_VEC(INTA_VEC), .WP_TOP(WP_TOP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .cpu_do(cpu_do),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .di(di), .wait_n(wait_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .wp_hit(wp_hit)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [7:0] ram_m [0:(1<<MEM_AW)-1];
    logic [7:0] io_m  [0:(1<<IO_AW)-1];
    bit         io_v  [0:(1<<IO_AW)-1];
    logic [7:0] exp_di;
    bit         exp_di_known;
    logic       exp_wait_n;
    logic       exp_wp;
    bit         busy, accessed;
    int         age, cur_load, lk;
    bit         chk_en = 1'b0;
    int         low_cnt;

    // kinds: 0 none, 1 MRD, 2 MWR, 3 IORD, 4 IOWR, 5 INTA
    function automatic int kind_of();
        if (!mreq_n && !rd_n && rfsh_n)    return 1;
        if (!mreq_n && !wr_n)              return 2;
        if (!iorq_n && !rd_n && m1_n)      return 3;
        if (!iorq_n && !wr_n)              return 4;
        if (!iorq_n && !m1_n)              return 5;
        return 0;
    endfunction

    function automatic int load_of(input int k);
        if (k == 1 || k == 2) return WAIT_MEM;
        if (k == 3 || k == 4) return WAIT_IO;
        return 0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected wait_n for the current inputs: low for cycle ages 0..load before the access.
    task automatic eval_comb();
        int k;
        k = kind_of();
        if (!reset_n)          exp_wait_n = 1'b1;
        else if (k == 0)       exp_wait_n = 1'b1;
        else if (!busy)        exp_wait_n = !(load_of(k) > 0);
        else if (!accessed)    exp_wait_n = !(age <= cur_load);
        else                   exp_wait_n = 1'b1;
    endtask

    // Model effect of one clock edge using the inputs the DUT sampled.
    task automatic edge_update();
        int k;
        bit mw, iw;
        k = kind_of();
        mw = 1'b0; iw = 1'b0;
        exp_wp = 1'b0;
        if (!reset_n) begin
            busy = 1'b0; exp_di = 8'hFF; exp_di_known = 1'b1;
            return;
        end
        case (k)
            1: begin exp_di = ram_m[A[MEM_AW-1:0]]; exp_di_known = 1'b1; end
            3: begin exp_di = io_m[A[IO_AW-1:0]]; exp_di_known = io_v[A[IO_AW-1:0]]; end
            5: begin exp_di = INTA_VEC; exp_di_known = 1'b1; end
            default: ;
        endcase
        if (!busy) begin
            if (k != 0) begin
                busy = 1'b1; accessed = 1'b0; lk = k; cur_load = load_of(k); age = 1;
            end
        end else if (!accessed) begin
            if (k == 0) busy = 1'b0;
            else if (age == cur_load + 1) begin
                accessed = 1'b1;
                if (lk == 2) begin
                    if (WP_ON && (A < WP_TOP)) exp_wp = 1'b1;
                    else mw = 1'b1;
                end
                if (lk == 4) iw = 1'b1;
            end else age++;
        end else if (mreq_n && iorq_n) begin
            busy = 1'b0;
        end
        if (mw) ram_m[A[MEM_AW-1:0]] = cpu_do;
        if (iw) begin io_m[A[IO_AW-1:0]] = cpu_do; io_v[A[IO_AW-1:0]] = 1'b1; end
        if (ld_we) ram_m[ld_addr] = ld_data;
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("wait_n", {7'd0, wait_n}, {7'd0, exp_wait_n});
            if (exp_di_known) check("di", di, exp_di);
            check("wp_hit", {7'd0, wp_hit}, {7'd0, exp_wp});
        end
    end

    // One clock: inputs already set at posedge+1; returns at next posedge+1.
    task automatic cyc();
        eval_comb();
        #3;
        if (!wait_n) low_cnt++;
        @(posedge clk);
        edge_update();
        #1;
    endtask

    task automatic drive(input int k, input logic [15:0] a, input logic [7:0] d);
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        A = a; cpu_do = d;
        case (k)
            1: begin mreq_n = 1'b0; rd_n = 1'b0; end
            2: begin mreq_n = 1'b0; wr_n = 1'b0; end
            3: begin iorq_n = 1'b0; rd_n = 1'b0; end
            4: begin iorq_n = 1'b0; wr_n = 1'b0; end
            5: begin iorq_n = 1'b0; m1_n = 1'b0; end
            6: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            default: ;
        endcase
    endtask

    // One bus cycle held for 'hold' clocks; cpu_do changes after the commit clock.
    task automatic bus(input int k, input logic [15:0] a, input logic [7:0] d, input int hold,
                       input int ld_cyc, input logic [11:0] la, input logic [7:0] ldd);
        low_cnt = 0;
        for (int i = 0; i < hold; i++) begin
            drive(k, a, (i > load_of(k) + 1) ? ~d : d);
            ld_we = (i == ld_cyc); ld_addr = la; ld_data = ldd;
            cyc();
        end
        drive(0, a, d);
        ld_we = 1'b0;
        cyc();
    endtask

    initial begin
        int k, hold, ldc;
        logic [7:0] v;
        reset_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = 8'h00;
        drive(0, 16'h0000, 8'h00);
        busy = 1'b0; accessed = 1'b0; age = 0; cur_load = 0; lk = 0;
        exp_di = 8'hFF; exp_di_known = 1'b1; exp_wait_n = 1'b1; exp_wp = 1'b0;
        for (int i = 0; i < (1 << IO_AW); i++) begin io_v[i] = 1'b0; io_m[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1;
        check("reset_di", di, 8'hFF);
        check("reset_wait_n", {7'd0, wait_n}, 8'd1);
        check("reset_wp_hit", {7'd0, wp_hit}, 8'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // preload the whole RAM
        for (int i = 0; i < (1 << MEM_AW); i++) begin
            case (i)
                12'h000: v = 8'hCB;
                12'h001: v = 8'h34;
                12'hB38: v = 8'h07;
                12'h100: v = 8'h5A;
                12'h200: v = 8'h11;
                12'h400: v = 8'h44;
                default: v = 8'($urandom);
            endcase
            ld_we = 1'b1; ld_addr = 12'(i); ld_data = v;
            cyc();
        end
        ld_we = 1'b0;

        // directed cases with hand-computed expectations
        bus(1, 16'hFB38, 8'h00, 5, -1, 12'h0, 8'h0);
        check("mirror_read", di, 8'h07);
        check("mem_wait_clks", 8'(low_cnt), 8'd3);
        bus(1, 16'h0100, 8'h00, 4, -1, 12'h0, 8'h0);
        check("read_0100", di, 8'h5A);
        bus(2, 16'h1B38, 8'h0F, 5, -1, 12'h0, 8'h0);
        bus(1, 16'h0B38, 8'h00, 4, -1, 12'h0, 8'h0);
        check("raw_next_cycle", di, 8'h0F);
        bus(4, 16'h0003, 8'hC3, 6, -1, 12'h0, 8'h0);
        check("io_wait_clks", 8'(low_cnt), 8'd2);
        bus(3, 16'h0013, 8'h00, 3, -1, 12'h0, 8'h0);
        check("io_single_commit", di, 8'hC3);
        bus(5, 16'h0000, 8'h00, 3, -1, 12'h0, 8'h0);
        check("inta_vec", di, 8'hE7);
        check("inta_wait_clks", 8'(low_cnt), 8'd0);
        bus(6, 16'h0100, 8'h00, 4, -1, 12'h0, 8'h0);
        check("refresh_no_wait", 8'(low_cnt), 8'd0);
        check("refresh_no_read", di, 8'hE7);
        bus(2, 16'h1300, 8'hAA, 5, 3, 12'h300, 8'h55);
        bus(1, 16'h0300, 8'h00, 4, -1, 12'h0, 8'h0);
        check("preload_wins", di, 8'h55);
        bus(2, 16'h1301, 8'h66, 5, 3, 12'h302, 8'h77);
        bus(1, 16'h0301, 8'h00, 4, -1, 12'h0, 8'h0);
        check("collide_cpu", di, 8'h66);
        bus(1, 16'h0302, 8'h00, 4, -1, 12'h0, 8'h0);
        check("collide_ld", di, 8'h77);
        bus(2, 16'h1400, 8'hBB, 2, -1, 12'h0, 8'h0);
        bus(1, 16'h0400, 8'h00, 4, -1, 12'h0, 8'h0);
        check("abort_no_write", di, 8'h44);

        // reset dropped during a waited memory write
        drive(2, 16'h1200, 8'hEE);
        cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_wait_n", {7'd0, wait_n}, 8'd1);
        check("rst_async_di", di, 8'hFF);
        busy = 1'b0; exp_di = 8'hFF; exp_di_known = 1'b1; exp_wp = 1'b0;
        drive(0, 16'h1200, 8'hEE);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        bus(1, 16'h0200, 8'h00, 4, -1, 12'h0, 8'h0);
        check("rst_no_write", di, 8'h11);

        // randomized bus traffic
        for (int n = 0; n < 700; n++) begin
            k    = int'($urandom_range(1, 6));
            hold = int'($urandom_range(1, 6));
            ldc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            bus(k, 16'($urandom), 8'($urandom), hold, ldc, 12'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
